// File: rtl/dcr_pkg.sv
// Shared types and constants for the dual-core instruction memory arbiter.
// Holds the arbiter state encoding and the default ROM address/data widths.
package dcr_pkg;

    localparam int DCR_ADDR_W = 8;
    localparam int DCR_DATA_W = 32;

    // Which core was granted in the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dcr_sat_counter.sv
// Saturating up-counter used for the arbiter performance statistics.
// Ports: clk, rst_n (async, active-low), i_inc (count enable), o_cnt (value, holds at all-ones).
module dcr_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dcr_imem_arbiter.sv
// Shares one 1-cycle-latency instruction ROM between two fetch stages using a
// bounded-burst round-robin grant; read data returns with a per-core valid.
// Ports: clk, rst_n (async, active-low); i_req0/1, i_addr0/1 fetch requests;
// o_gnt0/1 combinational grants; o_stall0/1 = req & ~gnt; o_rom_addr, i_rom_q
// ROM interface; o_rdata shared return bus; o_rvalid0/1 owner of o_rdata.
// Optional (DCR_IMEM_PERF_EN): o_perf_gnt0/1, o_perf_conflict 16-bit saturating counters.
module dcr_imem_arbiter
    import dcr_pkg::*;
#(
    parameter int ADDR_W    = DCR_ADDR_W,
    parameter int DATA_W    = DCR_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_stall0,
    output logic              o_stall1,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_q,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid0,
    output logic              o_rvalid1
`ifdef DCR_IMEM_PERF_EN
    ,
    output logic [15:0]       o_perf_gnt0,
    output logic [15:0]       o_perf_gnt1,
    output logic [15:0]       o_perf_conflict
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_last;
    logic             r_rvalid0;
    logic             r_rvalid1;

    logic             w_gnt0;
    logic             w_gnt1;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Grant decision. The burst counter only advances while the owner keeps
    // winning against a competing request; any hand-over or solo run clears it.
    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_cnt_nxt = '0;
        unique case (r_state)
            OWN0: begin
                if (i_req0 && i_req1) begin
                    if (r_burst_cnt < CNT_LAST) begin
                        w_gnt0    = 1'b1;
                        w_cnt_nxt = r_burst_cnt + CNT_W'(1);
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end else if (i_req0) begin
                    w_gnt0 = 1'b1;
                end else if (i_req1) begin
                    w_gnt1 = 1'b1;
                end
            end
            OWN1: begin
                if (i_req0 && i_req1) begin
                    if (r_burst_cnt < CNT_LAST) begin
                        w_gnt1    = 1'b1;
                        w_cnt_nxt = r_burst_cnt + CNT_W'(1);
                    end else begin
                        w_gnt0 = 1'b1;
                    end
                end else if (i_req1) begin
                    w_gnt1 = 1'b1;
                end else if (i_req0) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                // Tie from idle goes to the core that did not win last.
                if (i_req0 && i_req1) begin
                    if (r_last) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end else if (i_req0) begin
                    w_gnt0 = 1'b1;
                end else if (i_req1) begin
                    w_gnt1 = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_last      <= 1'b1;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            r_burst_cnt <= w_cnt_nxt;
            r_rvalid0   <= w_gnt0;
            r_rvalid1   <= w_gnt1;
            if (w_gnt0) begin
                r_state <= OWN0;
                r_last  <= 1'b0;
            end else if (w_gnt1) begin
                r_state <= OWN1;
                r_last  <= 1'b1;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign o_gnt0     = w_gnt0;
    assign o_gnt1     = w_gnt1;
    assign o_stall0   = i_req0 & ~w_gnt0;
    assign o_stall1   = i_req1 & ~w_gnt1;
    assign o_rom_addr = w_gnt1 ? i_addr1 : i_addr0;
    assign o_rdata    = i_rom_q;
    assign o_rvalid0  = r_rvalid0;
    assign o_rvalid1  = r_rvalid1;

`ifdef DCR_IMEM_PERF_EN
    dcr_sat_counter #(.WIDTH(16)) u_perf_gnt0 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_gnt0),
        .o_cnt (o_perf_gnt0)
    );

    dcr_sat_counter #(.WIDTH(16)) u_perf_gnt1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_gnt1),
        .o_cnt (o_perf_gnt1)
    );

    dcr_sat_counter #(.WIDTH(16)) u_perf_conflict (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (i_req0 & i_req1),
        .o_cnt (o_perf_conflict)
    );
`endif

endmodule

// File: tb/tb_dcr_imem_arbiter.sv
// Directed bench for dcr_imem_arbiter with a behavioural 1-cycle ROM and
// a scoreboard queue of expected read returns checked by a separate monitor.
module tb_dcr_imem_arbiter;

    typedef struct {
        logic        core;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic        gnt0;
    logic        gnt1;
    logic        stall0;
    logic        stall1;
    logic [7:0]  rom_addr;
    logic [31:0] rom_q;
    logic [31:0] rdata;
    logic        rvalid0;
    logic        rvalid1;
`ifdef DCR_IMEM_PERF_EN
    logic [15:0] perf_gnt0;
    logic [15:0] perf_gnt1;
    logic [15:0] perf_conflict;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    bit   sb_off = 0;
    exp_t q[$];

    dcr_imem_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (32),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_addr0    (addr0),
        .i_addr1    (addr1),
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_stall0   (stall0),
        .o_stall1   (stall1),
        .o_rom_addr (rom_addr),
        .i_rom_q    (rom_q),
        .o_rdata    (rdata),
        .o_rvalid0  (rvalid0),
        .o_rvalid1  (rvalid1)
`ifdef DCR_IMEM_PERF_EN
        ,
        .o_perf_gnt0     (perf_gnt0),
        .o_perf_gnt1     (perf_gnt1),
        .o_perf_conflict (perf_conflict)
`endif
    );

    function automatic logic [31:0] romval(input logic [7:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= romval(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus with the hand-computed grant for that cycle.
    task automatic apply(input logic r0, input logic r1,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic eg0, input logic eg1, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        req0  = r0;
        req1  = r1;
        addr0 = a0;
        addr1 = a1;
        #1;
        chk("gnt", {gnt0, gnt1}, {eg0, eg1});
        chk("stall", {stall0, stall1}, {r0 & ~eg0, r1 & ~eg1});
        chk("rom_addr", rom_addr, eg1 ? a1 : a0);
        if (push && (eg0 || eg1)) begin
            e.core = eg1;
            e.data = romval(eg1 ? a1 : a0);
            q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!sb_off && (rvalid0 || rvalid1)) begin
                chk("rvalid_onehot", {rvalid0 & rvalid1}, 1'b0);
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: got rv0=%0b rv1=%0b expected none", rvalid0, rvalid1);
                end else begin
                    e = q.pop_front();
                    chk("rvalid_core", {rvalid1, rvalid0}, e.core ? 2'b10 : 2'b01);
                    chk("rdata", rdata, e.data);
                end
            end
        end
    end

    initial begin : stim
        logic [11:0] pat;
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 8'h05;
        addr1 = 8'h06;
        #12;
        // In reset: idle state, last=1, so core 0 wins the tie combinationally.
        chk("rst_gnt", {gnt0, gnt1}, 2'b10);
        chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
        chk("rst_rom_addr", rom_addr, 8'h05);
`ifdef DCR_IMEM_PERF_EN
        chk("rst_perf", {perf_gnt0, perf_gnt1, perf_conflict}, 48'h0);
`endif
        req0 = 1'b0;
        req1 = 1'b0;
        #1 rst_n = 1'b1;

        // Reset while a read is in flight drops the result immediately.
        apply(1, 0, 8'h40, 8'h00, 1, 0, 0);
        @(posedge clk);
        #1 req0 = 1'b0;
        #1 chk("rvalid_before_rst", rvalid0, 1'b1);
        rst_n = 1'b0;
        #1 chk("rvalid_after_rst", rvalid0, 1'b0);
        #1 rst_n = 1'b1;

        // Contention from idle with last=1: 4 to core 0, 4 to core 1, 4 to core 0.
        pat = 12'b1111_0000_1111;
        for (int i = 0; i < 12; i++) begin
            apply(1, 1, 8'h20 + 8'(i), 8'h80 + 8'(i), pat[11-i], ~pat[11-i], 1);
        end

        // Solo core 0 run; burst count clears.
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 8'h10 + 8'(i), 8'h00, 1, 0, 1);
        end

        // Owner 0 at burst count 1 drops its request; core 1 takes over.
        apply(1, 1, 8'h30, 8'h90, 1, 0, 1);
        apply(0, 1, 8'h31, 8'h91, 0, 1, 1);
        apply(0, 0, 8'h55, 8'h66, 0, 0, 1);

        // Ties after idle alternate via last-winner.
        apply(1, 1, 8'h32, 8'h92, 1, 0, 1);
        apply(0, 0, 8'h56, 8'h67, 0, 0, 1);
        apply(1, 1, 8'h33, 8'h93, 0, 1, 1);
        apply(0, 0, 8'h57, 8'h68, 0, 0, 1);

        // Core 1 solo, then brief contention, then core 1 yields.
        apply(0, 1, 8'h34, 8'h94, 0, 1, 1);
        apply(1, 1, 8'h35, 8'h95, 0, 1, 1);
        apply(1, 0, 8'h36, 8'h96, 1, 0, 1);
        apply(0, 0, 8'h58, 8'h69, 0, 0, 1);
        apply(0, 0, 8'h59, 8'h6A, 0, 0, 1);
        chk("sb_drain", 64'(q.size()), 64'd0);

`ifdef DCR_IMEM_PERF_EN
        sb_off = 1;
        @(posedge clk);
        #1;
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("perf_conflict_sat", perf_conflict, 16'hFFFF);
        chk("perf_gnt_split", {perf_gnt0 >= 16'd34000, perf_gnt1 >= 16'd34000}, 2'b11);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 sb_off = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
